clk_div_gen: RTL and testbench

- Parametrised, runtime-reconfigurable multi-output clock generator built from fabric logic on one reference clock.
- Produces NUM_CLKS divided clocks and matching single-cycle enable strobes, each with a programmable integer divide ratio and phase offset.
- Provides a PLL-style locked indication that drops and re-asserts on every reconfiguration.
- Used where the project needs slow clock enables (pixel and memory strobes) derived from the board clock alongside the hard PLL.

---
 rtl/clk_div_gen.sv | 131 +++++++++++++
 tb/tb_clk_div_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// Runtime-reconfigurable multi-channel clock divider on a single reference clock.
// Every channel realigns after any write, and locked drops for the duration of the relock.
module clk_div_gen #(
  parameter int NUM_CLKS    = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int SEL_W       = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_phase,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] tick,
  output logic                locked
);

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    LOCKED  = 2'd1,
    RECONF  = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
  localparam logic [15:0]      LOCK_END = 16'(LOCK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [15:0]       lockCnt_q, lockCnt_d;
  logic              locked_q, locked_d;
  logic [DIV_W-1:0]  div_q   [NUM_CLKS];
  logic [DIV_W-1:0]  div_d   [NUM_CLKS];
  logic [DIV_W-1:0]  phase_q [NUM_CLKS];
  logic [DIV_W-1:0]  phase_d [NUM_CLKS];
  logic [DIV_W-1:0]  cnt_q   [NUM_CLKS];
  logic [DIV_W-1:0]  cnt_d   [NUM_CLKS];
  logic [DIV_W-1:0]  phaseEff[NUM_CLKS];
  logic [DIV_W-1:0]  cntRun  [NUM_CLKS];

  // Ratios 0 and 1 pin the counter at zero; otherwise wrap at div-1.
  always_comb begin
    for (int i = 0; i < NUM_CLKS; i++) begin
      phaseEff[i] = '0;
      cntRun[i]   = '0;
      if (div_q[i] >= TWO) begin
        phaseEff[i] = (phase_q[i] < div_q[i]) ? phase_q[i] : (div_q[i] - ONE);
        cntRun[i]   = (cnt_q[i] == (div_q[i] - ONE)) ? '0 : (cnt_q[i] + ONE);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lockCnt_d = lockCnt_q;
    locked_d  = locked_q;
    div_d     = div_q;
    phase_d   = phase_q;
    cnt_d     = cntRun;
    case (state_q)
      LOCKING: begin
        lockCnt_d = lockCnt_q + 16'd1;
        if (lockCnt_q == LOCK_END) begin
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (cfg_valid) begin
          locked_d = 1'b0;
          state_d  = RECONF;
          // Out-of-range selects match no channel but still force a realign.
          for (int i = 0; i < NUM_CLKS; i++) begin
            if (cfg_sel == SEL_W'(i)) begin
              div_d[i]   = cfg_div;
              phase_d[i] = cfg_phase;
            end
          end
        end
      end
      RECONF: begin
        lockCnt_d = '0;
        state_d   = LOCKING;
        cnt_d     = phaseEff;
      end
      default: begin
        state_d  = LOCKING;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOCKING;
      lockCnt_q <= '0;
      locked_q  <= 1'b0;
      for (int i = 0; i < NUM_CLKS; i++) begin
        div_q[i]   <= DIV_W'(DEFAULT_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      lockCnt_q <= lockCnt_d;
      locked_q  <= locked_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
    end
  end

  // High half is ceil(div/2), formed one bit wider so div = all-ones cannot wrap.
  always_comb begin
    outclk = '0;
    tick   = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (locked_q && (div_q[i] != '0)) begin
        outclk[i] = ({1'b0, cnt_q[i]} < (({1'b0, div_q[i]} + (DIV_W+1)'(1)) >> 1));
        tick[i]   = (cnt_q[i] == (div_q[i] - ONE));
      end
    end
  end

  assign cfg_ready = (state_q == LOCKED);
  assign locked    = locked_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: a time-based channel model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized reconfiguration.
module tb_clk_div_gen;

  localparam int NA   = 4;
  localparam int LCK  = 16;
  localparam int DEFD = 2;

  logic        refclk = 1'b0;
  logic        rst_n  = 1'b0;

  logic        cfgValidA = 1'b0;
  logic [1:0]  cfgSelA   = '0;
  logic [15:0] cfgDivA   = '0;
  logic [15:0] cfgPhaseA = '0;
  logic        cfgReadyA;
  logic [3:0]  outclkA, tickA;
  logic        lockedA;

  logic        cfgValidB = 1'b0;
  logic [0:0]  cfgSelB   = '0;
  logic [3:0]  cfgDivB   = '0;
  logic [3:0]  cfgPhaseB = '0;
  logic        cfgReadyB;
  logic [0:0]  outclkB, tickB;
  logic        lockedB;

  int tests  = 0;
  int failed = 0;

  always #5 refclk = ~refclk;

  clk_div_gen #(.NUM_CLKS(4), .DIV_W(16), .DEFAULT_DIV(DEFD), .LOCK_CYCLES(LCK)) dutA (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfgValidA), .cfg_ready(cfgReadyA),
    .cfg_sel(cfgSelA), .cfg_div(cfgDivA), .cfg_phase(cfgPhaseA),
    .outclk(outclkA), .tick(tickA), .locked(lockedA)
  );

  clk_div_gen #(.NUM_CLKS(1), .DIV_W(4), .DEFAULT_DIV(DEFD), .LOCK_CYCLES(LCK)) dutB (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfgValidB), .cfg_ready(cfgReadyB),
    .cfg_sel(cfgSelB), .cfg_div(cfgDivB), .cfg_phase(cfgPhaseB),
    .outclk(outclkB), .tick(tickB), .locked(lockedB)
  );

  // Model: each channel is described by the edge at which it was last aligned and the
  // phase it was aligned to; its position is (phase + elapsed edges) mod div.
  int mN;
  int mDivA[NA], mPhA[NA], mPeA[NA];
  int mAlignA, mLockAtA;
  int mDivB, mPhB, mPeB, mAlignB, mLockAtB;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int peOf(input int d, input int p);
    if (d < 2) return 0;
    return (p < d) ? p : d - 1;
  endfunction

  function automatic void expCh(input int d, input int pe, input int age, input bit lk,
                                output bit oc, output bit tk);
    int c;
    oc = 1'b0;
    tk = 1'b0;
    if (!lk || d == 0) return;
    if (d == 1) begin
      oc = 1'b1;
      tk = 1'b1;
      return;
    end
    c  = (pe + age) % d;
    oc = (c < (d + 1) / 2);
    tk = (c == d - 1);
  endfunction

  task automatic modelReset();
    mN = 0;
    for (int i = 0; i < NA; i++) begin
      mDivA[i] = DEFD;
      mPhA[i]  = 0;
      mPeA[i]  = 0;
    end
    mAlignA  = 0;
    mLockAtA = LCK;
    mDivB    = DEFD;
    mPhB     = 0;
    mPeB     = 0;
    mAlignB  = 0;
    mLockAtB = LCK;
  endtask

  task automatic compareAll();
    bit lk, oc, tk;
    logic [3:0] eo, et;
    eo = '0;
    et = '0;
    lk = rst_n && (mN >= mLockAtA);
    for (int i = 0; i < NA; i++) begin
      expCh(mDivA[i], mPeA[i], mN - mAlignA, lk, oc, tk);
      eo[i] = oc;
      et[i] = tk;
    end
    checkOutput("A.locked", 32'(lockedA), 32'(lk));
    checkOutput("A.cfg_ready", 32'(cfgReadyA), 32'(lk));
    checkOutput("A.outclk", 32'(outclkA), 32'(eo));
    checkOutput("A.tick", 32'(tickA), 32'(et));
    lk = rst_n && (mN >= mLockAtB);
    expCh(mDivB, mPeB, mN - mAlignB, lk, oc, tk);
    checkOutput("B.locked", 32'(lockedB), 32'(lk));
    checkOutput("B.cfg_ready", 32'(cfgReadyB), 32'(lk));
    checkOutput("B.outclk", 32'(outclkB), 32'(oc));
    checkOutput("B.tick", 32'(tickB), 32'(tk));
  endtask

  // A request counts only if the design was ready before this edge.
  always @(posedge refclk) begin
    if (!rst_n) begin
      modelReset();
    end else begin
      mN++;
      if (cfgValidA && (mN - 1) >= mLockAtA) begin
        mDivA[cfgSelA] = int'(cfgDivA);
        mPhA[cfgSelA]  = int'(cfgPhaseA);
        mAlignA  = mN + 1;
        mLockAtA = mN + 1 + LCK;
        for (int i = 0; i < NA; i++) mPeA[i] = peOf(mDivA[i], mPhA[i]);
      end
      if (cfgValidB && (mN - 1) >= mLockAtB) begin
        if (cfgSelB == 1'b0) begin
          mDivB = int'(cfgDivB);
          mPhB  = int'(cfgPhaseB);
        end
        mAlignB  = mN + 1;
        mLockAtB = mN + 1 + LCK;
        mPeB     = peOf(mDivB, mPhB);
      end
    end
    #1;
    compareAll();
  end

  task automatic applyStimulus(input bit toB, input int sel, input int div, input int ph);
    int waitCnt = 0;
    @(negedge refclk);
    while (!(toB ? cfgReadyB : cfgReadyA) && waitCnt < 200) begin
      @(negedge refclk);
      waitCnt++;
    end
    if (waitCnt >= 200) begin
      tests++;
      failed++;
      $display("[TB] FAIL cfg_ready.timeout: got 0 after 200 cycles, expected 1");
    end
    if (toB) begin
      cfgValidB = 1'b1;
      cfgSelB   = 1'(sel);
      cfgDivB   = 4'(div);
      cfgPhaseB = 4'(ph);
    end else begin
      cfgValidA = 1'b1;
      cfgSelA   = 2'(sel);
      cfgDivA   = 16'(div);
      cfgPhaseA = 16'(ph);
    end
    @(negedge refclk);
    cfgValidA = 1'b0;
    cfgValidB = 1'b0;
  endtask

  initial begin
    int hi, tk;
    modelReset();
    repeat (3) @(negedge refclk);
    checkOutput("lit.reset.outclk", 32'(outclkA), 32'h0);
    checkOutput("lit.reset.ready", 32'(cfgReadyA), 32'h0);
    rst_n = 1'b1;

    repeat (15) @(posedge refclk);
    #2;
    checkOutput("lit.locked@15", 32'(lockedA), 32'h0);
    @(posedge refclk);
    #2;
    checkOutput("lit.locked@16", 32'(lockedA), 32'h1);
    checkOutput("lit.ready@16", 32'(cfgReadyA), 32'h1);
    checkOutput("lit.outclk@16", 32'(outclkA), 32'hF);
    checkOutput("lit.tick@16", 32'(tickA), 32'h0);
    checkOutput("lit.B.locked@16", 32'(lockedB), 32'h1);
    @(posedge refclk);
    #2;
    checkOutput("lit.outclk@17", 32'(outclkA), 32'h0);
    checkOutput("lit.tick@17", 32'(tickA), 32'hF);

    applyStimulus(1'b0, 1, 5, 0);
    repeat (16) @(posedge refclk);
    #2;
    checkOutput("lit.ch1.relock16", 32'(lockedA), 32'h0);
    @(posedge refclk);
    #2;
    checkOutput("lit.ch1.relock17", 32'(lockedA), 32'h1);
    hi = 0;
    tk = 0;
    for (int k = 0; k < 5; k++) begin
      hi += int'(outclkA[1]);
      tk += int'(tickA[1]);
      @(posedge refclk);
      #2;
    end
    checkOutput("lit.ch1.highCycles", 32'(hi), 32'd3);
    checkOutput("lit.ch1.ticks", 32'(tk), 32'd1);

    applyStimulus(1'b0, 2, 4, 9);
    repeat (17) @(posedge refclk);
    #2;
    checkOutput("lit.ch2.firstTick", 32'(tickA[2]), 32'h1);

    applyStimulus(1'b0, 3, 0, 0);
    repeat (18) @(posedge refclk);
    #2;
    checkOutput("lit.ch3.div0.outclk", 32'(outclkA[3]), 32'h0);
    checkOutput("lit.ch3.div0.tick", 32'(tickA[3]), 32'h0);
    applyStimulus(1'b0, 3, 1, 0);
    repeat (18) @(posedge refclk);
    #2;
    checkOutput("lit.ch3.div1.outclk", 32'(outclkA[3]), 32'h1);
    checkOutput("lit.ch3.div1.tick", 32'(tickA[3]), 32'h1);

    // Requests while relocking must be dropped.
    applyStimulus(1'b0, 0, 7, 3);
    cfgValidA = 1'b1;
    cfgSelA   = 2'd0;
    cfgDivA   = 16'd9;
    cfgPhaseA = 16'd0;
    repeat (10) @(negedge refclk);
    cfgValidA = 1'b0;
    repeat (10) @(posedge refclk);
    #2;
    hi = 0;
    for (int k = 0; k < 7; k++) begin
      hi += int'(outclkA[0]);
      @(posedge refclk);
      #2;
    end
    checkOutput("lit.ch0.div7.highCycles", 32'(hi), 32'd4);

    // Reset while the design sits in RECONF.
    applyStimulus(1'b0, 1, 3, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("lit.midReconf.locked", 32'(lockedA), 32'h0);
    checkOutput("lit.midReconf.outclk", 32'(outclkA), 32'h0);
    @(negedge refclk);
    rst_n = 1'b1;
    repeat (17) @(posedge refclk);
    #2;
    checkOutput("lit.defaults.outclk", 32'(outclkA), 32'h0);
    checkOutput("lit.defaults.tick", 32'(tickA), 32'hF);

    applyStimulus(1'b1, 0, 15, 0);
    repeat (17) @(posedge refclk);
    #2;
    hi = 0;
    tk = 0;
    for (int k = 0; k < 15; k++) begin
      hi += int'(outclkB[0]);
      tk += int'(tickB[0]);
      @(posedge refclk);
      #2;
    end
    checkOutput("lit.B.div15.highCycles", 32'(hi), 32'd8);
    checkOutput("lit.B.div15.ticks", 32'(tk), 32'd1);

    repeat (3000) begin
      @(negedge refclk);
      rst_n     = ($urandom_range(0, 599) != 0);
      cfgValidA = ($urandom_range(0, 19) == 0);
      cfgSelA   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) cfgDivA = 16'($urandom_range(65533, 65535));
      else                            cfgDivA = 16'($urandom_range(0, 9));
      cfgPhaseA = 16'($urandom_range(0, 13));
      cfgValidB = ($urandom_range(0, 19) == 0);
      cfgSelB   = 1'($urandom_range(0, 1));
      cfgDivB   = 4'($urandom_range(0, 15));
      cfgPhaseB = 4'($urandom_range(0, 15));
    end
    @(negedge refclk);
    rst_n     = 1'b1;
    cfgValidA = 1'b0;
    cfgValidB = 1'b0;
    repeat (40) @(posedge refclk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
